// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory responder
//
// Holds the responder FSM state enum, word/byte-lane geometry, and the
// latency counter width. The counter only has to hold RD_LATENCY-1, which is
// at most 3 for the supported latency range of 1..4.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WORD_W  = 32;
  localparam int LANE_W  = 8;
  localparam int N_LANES = WORD_W / LANE_W;

  localparam logic [N_LANES-1:0] ALL_LANES = '1;

  localparam int MAX_RD_LATENCY = 4;
  localparam int CNT_W          = 2;

endpackage

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - word storage with lane-masked write and async read
//
// Purpose: DEPTH_WORDS x 32-bit storage. No reset: contents survive reset.
// Ports:
//   clk       in   clock; writes commit on the rising edge
//   i_we      in   write enable
//   i_lanes   in   per-byte-lane write enables
//   i_addr    in   word index shared by the read and write ports
//   i_wdata   in   write data
//   o_rdata   out  combinational read of the word at i_addr
module mem_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [N_LANES-1:0] i_lanes,
  input  logic [AW-1:0]      i_addr,
  input  logic [WORD_W-1:0]  i_wdata,
  output logic [WORD_W-1:0]  o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < N_LANES; i++) begin
        if (i_lanes[i]) begin
          r_mem[i_addr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side responder with fixed-latency response
//
// Purpose: accepts one byte-addressed read/write in IDLE, classifies it
// (misaligned / out of range -> fault), performs the word access at the
// acceptance edge and returns a one-cycle response RD_LATENCY edges later.
// Optional feature macro: MEM_BYTE_WRITE_EN (lane-masked writes via byte_en;
// when undefined every valid write replaces the full word).
// Ports:
//   clk         in   clock
//   reset       in   asynchronous active-low reset
//   addressIn   in   request byte address
//   req_valid   in   request present
//   req_write   in   1 = write, 0 = read
//   wdata       in   write data
//   byte_en     in   write lane enables
//   req_ready   out  high only in IDLE
//   rsp_valid   out  one-cycle response strobe
//   rdata       out  read data (0 for writes and faults)
//   fault       out  response is a fault
//   fault_addr  out  address of the last faulting request
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LATENCY  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         addressIn,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [WORD_W-1:0]   wdata,
  input  logic [N_LANES-1:0]  byte_en,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [WORD_W-1:0]   rdata,
  output logic                fault,
  output logic [31:0]         fault_addr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_accept;

  logic                w_misaligned;
  logic                w_out_of_range;
  logic                w_fault;
  logic                w_we;
  logic [N_LANES-1:0]  w_lanes;
  logic [AW-1:0]       w_idx;
  logic [WORD_W-1:0]   w_rd_word;
  logic [WORD_W-1:0]   w_live_data;

  logic                r_cap_fault;
  logic [WORD_W-1:0]   r_cap_data;
  logic [31:0]         r_cap_addr;

  logic                w_rsp_fault;
  logic [WORD_W-1:0]   w_rsp_data;
  logic [31:0]         w_rsp_addr;

  logic                r_fault;
  logic [WORD_W-1:0]   r_rdata;
  logic [31:0]         r_fault_addr;

  assign w_misaligned   = |addressIn[1:0];
  assign w_out_of_range = {2'b00, addressIn[31:2]} >= 32'(DEPTH_WORDS);
  assign w_fault        = w_misaligned | w_out_of_range;
  assign w_idx          = addressIn[AW+1:2];

`ifdef MEM_BYTE_WRITE_EN
  assign w_lanes = byte_en;
`else
  logic w_unused_byte_en;
  assign w_unused_byte_en = ^byte_en;
  assign w_lanes          = ALL_LANES;
`endif

  // Faulting requests never touch the array; writes commit on acceptance.
  assign w_we        = w_accept & req_write & ~w_fault;
  assign w_live_data = (w_fault | req_write) ? '0 : w_rd_word;

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_lanes (w_lanes),
    .i_addr  (w_idx),
    .i_wdata (wdata),
    .o_rdata (w_rd_word)
  );

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = (RD_LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_next = ST_RESP;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // With RD_LATENCY=1 RESP is entered on the acceptance edge itself, before
  // the capture registers are loaded, so the live classification is used.
  always_comb begin
    w_rsp_fault = r_cap_fault;
    w_rsp_data  = r_cap_data;
    w_rsp_addr  = r_cap_addr;
    if (r_state == ST_IDLE) begin
      w_rsp_fault = w_fault;
      w_rsp_data  = w_live_data;
      w_rsp_addr  = addressIn;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cap_fault  <= 1'b0;
      r_cap_data   <= '0;
      r_cap_addr   <= '0;
      r_fault      <= 1'b0;
      r_rdata      <= '0;
      r_fault_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt       <= CNT_W'(RD_LATENCY - 1);
        r_cap_fault <= w_fault;
        r_cap_data  <= w_live_data;
        r_cap_addr  <= addressIn;
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_next == ST_RESP) begin
        r_fault <= w_rsp_fault;
        r_rdata <= w_rsp_data;
        if (w_rsp_fault) r_fault_addr <= w_rsp_addr;
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = (r_state == ST_RESP);
  assign rdata      = r_rdata;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addressIn = '0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  byte_en = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        fault;
  logic [31:0] fault_addr;

  int checks = 0;
  int errors = 0;

  // Reference model: word contents, whether each word holds a known value,
  // and the address of the most recent faulting request.
  logic [31:0] mdl [DEPTH];
  bit          known [DEPTH];
  logic [31:0] last_fa = '0;

  mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .RD_LATENCY  (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addressIn  (addressIn),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .wdata      (wdata),
    .byte_en    (byte_en),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rdata      (rdata),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  always #5 clk = ~clk;

  function automatic bit byte_mode();
`ifdef MEM_BYTE_WRITE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_fault(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  // One full transaction; the model is updated as of the acceptance edge.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input string nm);
    int          edges;
    bit          exp_f;
    bit          chk_d;
    logic [31:0] exp_d;
    int          w;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before got %b exp 1", nm, req_ready);
    end
    req_valid = 1'b1; req_write = wr; addressIn = a; wdata = wd; byte_en = be;
    @(posedge clk);
    exp_f = is_fault(a);
    w     = int'(a / 4);
    chk_d = 1'b1;
    exp_d = '0;
    if (!exp_f && !wr) begin
      chk_d = known[w];
      exp_d = mdl[w];
    end
    if (!exp_f && wr) begin
      for (int i = 0; i < 4; i++)
        if (!byte_mode() || be[i]) mdl[w][8*i +: 8] = wd[8*i +: 8];
      if (!byte_mode() || be == 4'hF) known[w] = 1'b1;
    end
    if (exp_f) last_fa = a;
    @(negedge clk);
    req_valid = 1'b0;
    edges = 0;
    while (rsp_valid !== 1'b1 && edges < 20) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    checks++;
    if (edges != LAT) begin
      errors++; $display("FAIL %s latency got %0d exp %0d", nm, edges, LAT);
    end
    checks++;
    if (fault !== exp_f) begin
      errors++; $display("FAIL %s fault got %b exp %b", nm, fault, exp_f);
    end
    if (chk_d) begin
      checks++;
      if (rdata !== exp_d) begin
        errors++; $display("FAIL %s rdata got %h exp %h", nm, rdata, exp_d);
      end
    end
    checks++;
    if (fault_addr !== last_fa) begin
      errors++; $display("FAIL %s fault_addr got %h exp %h", nm, fault_addr, last_fa);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s rsp_one_cycle got %b exp 0", nm, rsp_valid);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
    checks++; if (fault_addr !== 32'h0) begin errors++; $display("FAIL reset_fault_addr got %h exp 0", fault_addr); end
    reset = 1'b1;
    last_fa = '0;
  endtask

  task automatic test_basic();
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "basic_wr");
    txn(1'b0, 32'h10, 32'h0, 4'h0, "basic_rd");
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_rd_const got %h exp deadbeef", rdata);
    end
  endtask

  task automatic test_misaligned();
    txn(1'b1, 32'h4, 32'hCAFE0004, 4'hF, "mis_pre");
    txn(1'b0, 32'h6, 32'h0, 4'h0, "mis_rd");
    checks++;
    if (fault_addr !== 32'h6) begin
      errors++; $display("FAIL mis_fault_addr got %h exp 00000006", fault_addr);
    end
    txn(1'b0, 32'h4, 32'h0, 4'h0, "mis_after");
  endtask

  task automatic test_out_of_range();
    txn(1'b1, 32'h0, 32'h0BADF00D, 4'hF, "oor_pre");
    txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, "oor_wr");
    txn(1'b0, 32'h0, 32'h0, 4'h0, "oor_alias");
    checks++;
    if (rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL oor_alias_const got %h exp 0badf00d", rdata);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] exp_v;
    exp_v = byte_mode() ? 32'h1122AB44 : 32'h0000AB00;
    txn(1'b1, 32'h20, 32'h11223344, 4'hF, "bw_pre");
    txn(1'b1, 32'h20, 32'h0000AB00, 4'b0010, "bw_wr");
    txn(1'b0, 32'h20, 32'h0, 4'h0, "bw_rd");
    checks++;
    if (rdata !== exp_v) begin
      errors++; $display("FAIL bw_const got %h exp %h", rdata, exp_v);
    end
    txn(1'b1, 32'h20, 32'h55667788, 4'b0000, "bw_none");
    txn(1'b0, 32'h20, 32'h0, 4'h0, "bw_none_rd");
  endtask

  task automatic test_hold_valid();
    int n_rsp;
    int bad_ready;
    int cyc;
    n_rsp = 0; bad_ready = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; addressIn = 32'h10; byte_en = 4'h0;
    @(posedge clk);
    for (cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (n_rsp == 0 && req_ready !== 1'b0) bad_ready++;
      if (rsp_valid === 1'b1) begin
        n_rsp++;
        req_valid = 1'b0;
      end
      @(posedge clk);
    end
    req_valid = 1'b0;
    checks++;
    if (n_rsp != 1) begin errors++; $display("FAIL hold_rsp_count got %0d exp 1", n_rsp); end
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL hold_ready_low got %0d bad exp 0", bad_ready); end
  endtask

  task automatic reset_in_wait(input bit wr, input logic [31:0] a, input logic [31:0] wd, input string nm);
    int seen;
    seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; addressIn = a; wdata = wd; byte_en = 4'hF;
    @(posedge clk);
    if (wr) begin mdl[a/4] = wd; known[a/4] = 1'b1; end
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s ready_now got %b exp 1", nm, req_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    reset = 1'b1;
    last_fa = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL %s rsp_dropped got %0d strobes exp 0", nm, seen); end
  endtask

  task automatic test_reset_mid();
    reset_in_wait(1'b0, 32'h10, 32'h0, "rst_rd");
    txn(1'b0, 32'h10, 32'h0, 4'h0, "rst_rd_next");
    reset_in_wait(1'b1, 32'h30, 32'h13572468, "rst_wr");
    txn(1'b0, 32'h30, 32'h0, 4'h0, "rst_wr_kept");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          kind;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7)      a = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
      else if (kind < 8) a = {$urandom_range(0, 63)} * 4 + {30'h0, 2'($urandom_range(1, 3))};
      else if (kind < 9) a = 32'h400 + {$urandom_range(0, 1023)} * 4;
      else               a = $urandom;
      txn(($urandom_range(0, 1) == 1), a, $urandom, 4'($urandom_range(0, 15)), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; known[i] = 1'b0; end
    test_reset();
    test_basic();
    test_misaligned();
    test_out_of_range();
    test_byte_write();
    test_hold_valid();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
